// File: rtl/rca_8bit.sv
// Registered 8-bit ripple-carry adder: eight chained full-adder cells feeding
// a 9-bit {carry-out, sum} output register with synchronous active-low reset.

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module rca_8bit (
    input  logic       clk,
    input  logic       rst_n,
    output logic       Cout,
    output logic [7:0] Sum,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin
);
    logic [8:0] carry;
    logic [7:0] sum_comb;

    assign carry[0] = Cin;

    // Carry is passed cell to cell so the ripple path stays explicit.
    for (genvar i = 0; i < 8; i++) begin : g_cell
        full_adder_cell u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .ci (carry[i]),
            .s  (sum_comb[i]),
            .co (carry[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Cout <= 1'b0;
            Sum  <= 8'h00;
        end else begin
            Cout <= carry[8];
            Sum  <= sum_comb;
        end
    end
endmodule

// File: tb/tb_rca_8bit.sv
// Self-checking bench for rca_8bit: directed cases plus random vectors
// compared against a plain-arithmetic reference with one cycle of latency.

module tb_rca_8bit;
    logic       clk;
    logic       rst_n;
    logic       Cout;
    logic [7:0] Sum;
    logic [7:0] A;
    logic [7:0] B;
    logic       Cin;

    int n_checks = 0;
    int n_fail   = 0;

    rca_8bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .Cout  (Cout),
        .Sum   (Sum),
        .A     (A),
        .B     (B),
        .Cin   (Cin)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one vector, clock it in, then compare {Cout,Sum} against exp.
    task automatic step(input logic r, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input int exp, input string tag);
        logic [8:0] res;
        rst_n = r;
        A     = a;
        B     = b;
        Cin   = c;
        @(posedge clk);
        #1;
        res = {Cout, Sum};
        if ($isunknown(res)) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got X/Z, expected %0d", tag, exp);
        end else begin
            check_val(tag, int'(res), exp);
        end
    endtask

    function automatic int ref_add(input logic r, input logic [7:0] a,
                                   input logic [7:0] b, input logic c);
        return r ? (int'(a) + int'(b) + int'(c)) : 0;
    endfunction

    initial begin
        rst_n = 1'b0;
        A     = 8'hFF;
        B     = 8'hFF;
        Cin   = 1'b1;
        #2;

        step(1'b0, 8'hFF, 8'hFF, 1'b1, 0,   "reset_edge1");
        step(1'b0, 8'hFF, 8'hFF, 1'b1, 0,   "reset_edge2");
        step(1'b1, 8'hFF, 8'hFF, 1'b1, 511, "reset_release");

        step(1'b1, 8'd145, 8'd83, 1'b0, 228, "add_145_83");
        step(1'b1, 8'd24,  8'd20, 1'b1, 45,  "add_24_20_c");
        step(1'b1, 8'd3,   8'd0,  1'b0, 3,   "add_3_0");
        step(1'b1, 8'd7,   8'd3,  1'b1, 11,  "add_7_3_c");
        step(1'b1, 8'd11,  8'd3,  1'b0, 14,  "add_11_3");

        step(1'b1, 8'd233, 8'd44, 1'b1, 256 + 22, "carry_233_44");
        step(1'b1, 8'd87,  8'd20, 1'b0, 107,      "nocarry_87_20");

        step(1'b1, 8'd255, 8'd0,   1'b1, 256, "ripple_255_0_c");
        step(1'b1, 8'd128, 8'd128, 1'b0, 256, "ripple_128_128");

        step(1'b1, 8'd99, 8'd10, 1'b1, 110, "b2b_99_10");
        step(1'b0, 8'd1,  8'd1,  1'b0, 0,   "midstream_reset");
        step(1'b1, 8'd1,  8'd1,  1'b0, 2,   "after_reset");

        for (int i = 0; i < 1200; i++) begin
            logic       r;
            logic [7:0] a;
            logic [7:0] b;
            logic       c;
            r = ($urandom_range(0, 31) != 0);
            a = 8'($urandom);
            b = 8'($urandom);
            c = 1'($urandom);
            step(r, a, b, c, ref_add(r, a, b, c), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
